// File: rtl/gpu_irq_req.sv
// Interrupt-request sequencer in front of the GPU IRQ latch: queues GP0 0x1F
// requests, waits for an idle settle window, and emits set/clear pulses.
module gpu_irq_req #(
  parameter int PEND_W      = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int IDLE_W      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_gp0Valid,
  input  logic [7:0]        i_gp0Cmd,
  output logic              o_gp0Ready,
  input  logic              i_gp1Write,
  input  logic [7:0]        i_gp1Cmd,
  input  logic              i_engineBusy,
  output logic              o_setIRQ,
  output logic              o_rstIRQ,
  output logic [PEND_W-1:0] o_pendCount,
  output logic [1:0]        o_dbgState
);

  // GP0 handshake: a command transfers in any cycle where i_gp0Valid and
  // o_gp0Ready are both high; ready never depends on valid.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              rst_irq_q, rst_irq_d;

  logic gp1_ack, gp1_rst, accept, issue;

  assign gp1_ack    = i_gp1Write && (i_gp1Cmd == 8'h02);
  assign gp1_rst    = i_gp1Write && (i_gp1Cmd == 8'h00);
  assign o_gp0Ready = (i_gp0Cmd == 8'h1F) && (pend_q != PEND_MAX) && !i_rst;
  assign accept     = i_gp0Valid && o_gp0Ready;
  assign issue      = (state_q == ST_ISSUE);

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    pend_d    = pend_q;
    rst_irq_d = gp1_ack || gp1_rst;

    if (accept && !issue) begin
      pend_d = pend_q + 1'b1;
    end else if (!accept && issue) begin
      pend_d = pend_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (pend_q != '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_engineBusy) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          // Hold back one cycle if an acknowledge would clear the latch
          // in the same cycle we set it; the set then lands after the clear.
          if (!gp1_ack) state_d = ST_ISSUE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        idle_d  = '0;
        state_d = (pend_d != '0) ? ST_DRAIN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idle_d  = '0;
      end
    endcase

    if (gp1_rst) begin
      pend_d  = '0;
      state_d = ST_IDLE;
      idle_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idle_q    <= '0;
      pend_q    <= '0;
      rst_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      pend_q    <= pend_d;
      rst_irq_q <= rst_irq_d;
    end
  end

  assign o_setIRQ    = issue;
  assign o_rstIRQ    = rst_irq_q;
  assign o_pendCount = pend_q;
  assign o_dbgState  = state_q;

endmodule

// File: tb/tb_gpu_irq_req.sv
// Directed bench for gpu_irq_req: each scenario drives a cycle-indexed
// sequence and checks pulses, pending count and ready against hand timing.
module tb_gpu_irq_req;

  logic       clk = 1'b0;
  logic       rst;
  logic       gp0_valid;
  logic [7:0] gp0_cmd;
  logic       gp0_ready;
  logic       gp1_write;
  logic [7:0] gp1_cmd;
  logic       busy;
  logic       set_irq;
  logic       rst_irq;
  logic [1:0] pend_count;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  gpu_irq_req #(.PEND_W(2), .IDLE_CYCLES(4), .IDLE_W(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_gp0Valid   (gp0_valid),
    .i_gp0Cmd     (gp0_cmd),
    .o_gp0Ready   (gp0_ready),
    .i_gp1Write   (gp1_write),
    .i_gp1Cmd     (gp1_cmd),
    .i_engineBusy (busy),
    .o_setIRQ     (set_irq),
    .o_rstIRQ     (rst_irq),
    .o_pendCount  (pend_count),
    .o_dbgState   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @c%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive its inputs, let combinational logic settle.
  task automatic drive(input logic v, input logic [7:0] c, input logic w,
                       input logic [7:0] gc, input logic b);
    @(posedge clk);
    #1;
    gp0_valid = v;
    gp0_cmd   = c;
    gp1_write = w;
    gp1_cmd   = gc;
    busy      = b;
    #1;
  endtask

  task automatic chk_cycle(input string tag, input int cyc, input logic es,
                           input logic er, input logic [1:0] ep);
    chk({tag, "_set"}, cyc, 32'(set_irq), 32'(es));
    chk({tag, "_rst"}, cyc, 32'(rst_irq), 32'(er));
    chk({tag, "_pend"}, cyc, 32'(pend_count), 32'(ep));
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 8'hFF, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    gp0_valid = 1'b0; gp0_cmd = 8'h1F; gp1_write = 1'b0; gp1_cmd = 8'hFF; busy = 1'b0;
    #1;
    chk("ready_in_reset", 0, 32'(gp0_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cycle("reset", 0, 1'b0, 1'b0, 2'd0);
    chk("reset_state", 0, 32'(dbg_state), 32'd0);
    settle();

    // Single request, engine idle: set in cycle 6, pending 1 in cycles 1..6.
    for (int c = 0; c <= 9; c++) begin
      drive(c == 0, 8'h1F, 1'b0, 8'hFF, 1'b0);
      if (c == 0) chk("t1_ready", c, 32'(gp0_ready), 32'd1);
      chk_cycle("t1", c, c == 6, 1'b0, (c >= 1 && c <= 6) ? 2'd1 : 2'd0);
    end
    settle();

    // Busy 0..19 plus a glitch at 22: window restarts, set lands at cycle 27.
    for (int c = 0; c <= 30; c++) begin
      drive(c == 0, 8'h1F, 1'b0, 8'hFF, (c <= 19) || (c == 22));
      chk_cycle("t2", c, c == 27, 1'b0, (c >= 1 && c <= 27) ? 2'd1 : 2'd0);
    end
    settle();

    // Three accepted back-to-back, a fourth stalls while the counter is full.
    for (int c = 0; c <= 19; c++) begin
      logic [1:0] ep;
      drive(c <= 5, 8'h1F, 1'b0, 8'hFF, 1'b0);
      if (c <= 5) chk("t3_ready", c, 32'(gp0_ready), 32'(c <= 2));
      if (c == 0)       ep = 2'd0;
      else if (c <= 2)  ep = 2'(c);
      else if (c <= 6)  ep = 2'd3;
      else if (c <= 11) ep = 2'd2;
      else if (c <= 16) ep = 2'd1;
      else              ep = 2'd0;
      chk_cycle("t3", c, (c == 6) || (c == 11) || (c == 16), 1'b0, ep);
    end
    settle();

    // Acknowledge in the DRAIN->ISSUE cycle: clear at 6, set deferred to 7.
    for (int c = 0; c <= 10; c++) begin
      drive(c == 0, 8'h1F, c == 5, 8'h02, 1'b0);
      chk_cycle("t4", c, c == 7, c == 6, (c >= 1 && c <= 7) ? 2'd1 : 2'd0);
      if (c == 6) chk("t4_state", c, 32'(dbg_state), 32'd1);
    end
    settle();

    // GP1 reset with two pending mid-DRAIN; the simultaneous accept is dropped.
    for (int c = 0; c <= 14; c++) begin
      logic [1:0] ep;
      drive((c <= 1) || (c == 3), 8'h1F, c == 3, 8'h00, 1'b0);
      if (c == 3) begin
        chk("t5_ready", c, 32'(gp0_ready), 32'd1);
        chk("t5_state_pre", c, 32'(dbg_state), 32'd1);
      end
      if (c == 0)      ep = 2'd0;
      else if (c == 1) ep = 2'd1;
      else if (c <= 3) ep = 2'd2;
      else             ep = 2'd0;
      chk_cycle("t5", c, 1'b0, c == 4, ep);
      if (c == 4) chk("t5_state_post", c, 32'(dbg_state), 32'd0);
    end
    settle();

    // Foreign opcodes ignored, then a synchronous reset mid-DRAIN.
    for (int c = 0; c <= 14; c++) begin
      if (c == 0) drive(1'b1, 8'h02, 1'b1, 8'h01, 1'b0);
      else        drive((c == 4) || (c == 7), 8'h1F, 1'b0, 8'hFF, 1'b0);
      if (c == 7) begin
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", c, 32'(gp0_ready), 32'd0);
        chk("t6_state_pre", c, 32'(dbg_state), 32'd1);
      end
      if (c == 8) rst = 1'b0;
      if (c == 0) chk("t6_ready_op02", c, 32'(gp0_ready), 32'd0);
      chk_cycle("t6", c, 1'b0, 1'b0, (c >= 5 && c <= 7) ? 2'd1 : 2'd0);
      if (c == 8) chk("t6_state_post", c, 32'(dbg_state), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Pulses must never overlap; checked on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      assert (!(set_irq && rst_irq)) else begin
        n_err++;
        $error("FAIL overlap observed set=%0b rst=%0b expected not both", set_irq, rst_irq);
      end
    end
  end

endmodule
